pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. It turns stall and redirect requests from the decode, execute and memory stages into per-stage register enables, flushes and a PC redirect. It also holds a redirect that arrives while memory is busy until the pipeline can take it, and keeps performance counters for cycles, stalls and flushes. It sits beside the pipeline registers and drives their `en`/`flush` pins and the fetch PC mux.

## Interface
Parameters:
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_stall_req`  in  1  decode has an operand hazard that forwarding cannot cover (load-use).
- `id_force_jump`  in  1  decode holds `j`, `jal` or `jr`.
- `id_next_pc`  in  32  jump target from decode.
- `ex_branch_valid`  in  1  execute holds a resolved conditional branch.
- `ex_branch_taken`  in  1  actual outcome of that branch.
- `ex_pred_taken`  in  1  prediction carried down from fetch for that branch.
- `ex_branch_pc`  in  32  taken target.
- `ex_pc`  in  32  PC of the branch.
- `mem_busy`  in  1  data memory is not ready; the whole pipeline must freeze.
- `pc_write`  out  1  fetch PC register enable.
- `redirect`  out  1  fetch PC takes `redirect_pc` instead of its predicted next PC.
- `redirect_pc`  out  32  redirect target.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  pipeline register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble (all-zero NOP) into the register.
- `cycle_cnt`, `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters.

## Operation
Mispredict: `mispredict = ex_branch_valid && (ex_branch_taken != ex_pred_taken)`.

Correct target: `ex_branch_taken ? ex_branch_pc : ex_pc + 4`, computed modulo 2^32.

States:
- RUN: normal operation.
- HOLD: a mispredict is latched and memory is still busy.

Priority in RUN, evaluated each cycle, highest first:
1. `mem_busy`
   - All enables are 0 and both flushes are 0.
   - `pc_write` is 0.
   - If `mispredict` is also high, latch `pend_pc` = correct target and go to HOLD. Execute stays frozen, but the branch is still reported, so the target is captured once.
2. `mispredict`
   - `redirect` is 1 and `redirect_pc` = correct target; `pc_write` is 1.
   - `if_id_flush` and `id_ex_flush` are 1; all enables are 1.
   - `id_stall_req` and `id_force_jump` are ignored, because the decode instruction is on the wrong path.
3. `id_stall_req`
   - `pc_write` is 0 and `if_id_en` is 0.
   - `id_ex_flush` is 1 (bubble).
   - `ex_mem_en` and `mem_wb_en` are 1.
   - Any jump is deferred until the stall clears.
4. `id_force_jump`
   - `redirect` is 1 and `redirect_pc` = `id_next_pc`; `pc_write` is 1.
   - `if_id_flush` is 1; all enables are 1.
5. Otherwise all enables are 1, `pc_write` is 1, and flushes and `redirect` are 0.

HOLD:
- While `mem_busy` is high, the outputs are the same as the frozen case.
- On the first cycle `mem_busy` is low, act as a mispredict using `pend_pc`:
  - Set `redirect`, both flushes and all enables; return to RUN.
  - Live `ex_*` inputs are ignored in that cycle.
- `mem_busy` has no priority over the stored redirect beyond delaying it.

Flushes imply their register enable is 1: a flush writes the NOP.

Counters:
- `cycle_cnt` increments every non-reset cycle.
- `stall_cnt` increments on any cycle with `pc_write` = 0.
- `flush_cnt` increments once per cycle with `if_id_flush` = 1.
- All counters wrap from 2^`CNT_W`−1 to 0.

## Timing
- All control outputs are combinational from the current inputs plus the registered state and `pend_pc`. There is zero latency: a request affects the same edge.
- A redirect takes effect at the edge it is asserted; the target is fetched the following cycle.
- Mispredict penalty is 2 bubbles. Jump penalty is 1 bubble. Load-use costs 1 cycle per asserted cycle of `id_stall_req`.
- Reset (`rst` high at an edge):
  - state = RUN, `pend_pc` = 0, all counters = 0.
  - While `rst` is high, outputs are forced to: `pc_write` 0, `redirect` 0, `redirect_pc` 0, all enables 0, both flushes 1.
- Reset asserted in HOLD discards the pending redirect.
- Counters are registered and reflect events up to the previous edge.

## Test plan
- Straight-line run, all requests 0, for 10 cycles → every enable and `pc_write` is 1, flushes 0, `cycle_cnt` = 10, `stall_cnt` = 0.
- `id_stall_req` high for 2 cycles → `pc_write` and `if_id_en` are 0 and `id_ex_flush` is 1 for exactly 2 cycles; `stall_cnt` = 2.
- Mispredict with `ex_pred_taken`=1, `ex_branch_taken`=0, `ex_pc`=0x0000_0040, and `id_force_jump`=1 in the same cycle → `redirect_pc` = 0x0000_0044, both flushes 1, jump ignored; `flush_cnt` +1.
- Mispredict during `mem_busy`=1 held 3 cycles, taken to `ex_branch_pc`=0x0000_1000 → no redirect for 3 cycles. On the 4th cycle: `redirect`=1, `redirect_pc`=0x0000_1000, flushes 1, state returns to RUN.
- `id_force_jump` with `id_next_pc`=0x0040_0020 while `id_stall_req`=1 → stall cycle first, with no redirect. The next cycle (stall low) gives `redirect_pc` = 0x0040_0020 and `if_id_flush` = 1.
- Reset asserted in HOLD, then released → no redirect after release, counters 0.
- Counter wrap with `CNT_W`=4 → `cycle_cnt` goes 15 → 0 on the 16th cycle.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Request and control bundle between the pipeline stages and pipeline_ctrl.
// The slave modport is the controller; the master modport is the pipeline side that raises requests.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              id_stall_req;
  logic              id_force_jump;
  logic [31:0]       id_next_pc;
  logic              ex_branch_valid;
  logic              ex_branch_taken;
  logic              ex_pred_taken;
  logic [31:0]       ex_branch_pc;
  logic [31:0]       ex_pc;
  logic              mem_busy;

  logic              pc_write;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              state_dbg;

  // No valid/ready pairing here: every request is level-sensitive and is acted on
  // in the same cycle it is high; the controller never back-pressures a requester.
  modport slave (
    input  id_stall_req, id_force_jump, id_next_pc,
    input  ex_branch_valid, ex_branch_taken, ex_pred_taken, ex_branch_pc, ex_pc,
    input  mem_busy,
    output pc_write, redirect, redirect_pc,
    output if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush,
    output cycle_cnt, stall_cnt, flush_cnt, state_dbg
  );

  modport master (
    output id_stall_req, id_force_jump, id_next_pc,
    output ex_branch_valid, ex_branch_taken, ex_pred_taken, ex_branch_pc, ex_pc,
    output mem_busy,
    input  pc_write, redirect, redirect_pc,
    input  if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush,
    input  cycle_cnt, stall_cnt, flush_cnt, state_dbg
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: per-stage enables, flushes,
// PC redirect, a held redirect while memory is busy, and cycle/stall/flush counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_ctrl_if.slave      bus
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_pend_pc;
  logic [31:0]      w_next_pend_pc;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_mispredict;
  logic [31:0]      w_target;
  logic             w_pc_write;
  logic             w_redirect;
  logic [31:0]      w_redirect_pc;
  logic             w_if_id_en;
  logic             w_id_ex_en;
  logic             w_ex_mem_en;
  logic             w_mem_wb_en;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;

  assign w_mispredict = bus.ex_branch_valid && (bus.ex_branch_taken != bus.ex_pred_taken);
  assign w_target     = bus.ex_branch_taken ? bus.ex_branch_pc : (bus.ex_pc + 32'd4);

  always_comb begin
    w_pc_write     = 1'b1;
    w_redirect     = 1'b0;
    w_redirect_pc  = 32'd0;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_next_state   = r_state;
    w_next_pend_pc = r_pend_pc;

    if (rst) begin
      w_pc_write     = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_next_state   = RUN;
      w_next_pend_pc = 32'd0;
    end else if (bus.mem_busy) begin
      // Whole pipeline frozen; execute keeps reporting the branch, so capture it only from RUN.
      w_pc_write  = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
      if (r_state == RUN && w_mispredict) begin
        w_next_state   = HOLD;
        w_next_pend_pc = w_target;
      end
    end else begin
      case (r_state)
        HOLD: begin
          w_redirect    = 1'b1;
          w_redirect_pc = r_pend_pc;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_next_state  = RUN;
        end
        default: begin
          if (w_mispredict) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_target;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (bus.id_stall_req) begin
            w_pc_write    = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end else if (bus.id_force_jump) begin
            w_redirect    = 1'b1;
            w_redirect_pc = bus.id_next_pc;
            w_if_id_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_pend_pc   <= 32'd0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pend_pc   <= w_next_pend_pc;
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (!w_pc_write)   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_if_id_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.redirect    = w_redirect;
  assign bus.redirect_pc = w_redirect_pc;
  assign bus.if_id_en    = w_if_id_en;
  assign bus.id_ex_en    = w_id_ex_en;
  assign bus.ex_mem_en   = w_ex_mem_en;
  assign bus.mem_wb_en   = w_mem_wb_en;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
  assign bus.state_dbg   = (r_state == HOLD);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, checked against a
// cycle-level reference model through an expected-response queue; a CNT_W=4 copy checks wrap.
module tb_pipeline_ctrl;

  logic clk = 1'b1;
  logic rst;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.id_stall_req    = bus.id_stall_req;
  assign bus4.id_force_jump   = bus.id_force_jump;
  assign bus4.id_next_pc      = bus.id_next_pc;
  assign bus4.ex_branch_valid = bus.ex_branch_valid;
  assign bus4.ex_branch_taken = bus.ex_branch_taken;
  assign bus4.ex_pred_taken   = bus.ex_pred_taken;
  assign bus4.ex_branch_pc    = bus.ex_branch_pc;
  assign bus4.ex_pc           = bus.ex_pc;
  assign bus4.mem_busy        = bus.mem_busy;

  pipeline_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
  pipeline_ctrl #(.CNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct packed {
    logic        known;
    logic        chk_pc;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [3:0]  en;
    logic [1:0]  flush;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: a pending redirect and three event tallies.
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_cyc, m_stl, m_fls;
  logic        m_known;

  initial begin
    m_pend = 1'b0; m_pend_pc = 32'd0; m_cyc = 0; m_stl = 0; m_fls = 0; m_known = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit jp, input logic [31:0] npc,
                      input bit bv, input bit bt, input bit pt,
                      input logic [31:0] bpc, input logic [31:0] epc, input bit busy);
    exp_t e;
    bit mis;
    logic [31:0] tgt;
    rst                 = r;
    bus.id_stall_req    = st;
    bus.id_force_jump   = jp;
    bus.id_next_pc      = npc;
    bus.ex_branch_valid = bv;
    bus.ex_branch_taken = bt;
    bus.ex_pred_taken   = pt;
    bus.ex_branch_pc    = bpc;
    bus.ex_pc           = epc;
    bus.mem_busy        = busy;

    mis = bv && (bt != pt);
    tgt = bt ? bpc : epc + 32'd4;
    e.known = m_known; e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
    e.chk_pc = 1'b0; e.redirect = 1'b0; e.redirect_pc = 32'd0;
    e.pc_write = 1'b1; e.en = 4'b1111; e.flush = 2'b00;

    if (r) begin
      e.pc_write = 1'b0; e.en = 4'b0000; e.flush = 2'b11; e.chk_pc = 1'b1;
      m_pend = 1'b0; m_pend_pc = 32'd0;
    end else if (busy) begin
      e.pc_write = 1'b0; e.en = 4'b0000;
      if (!m_pend && mis) begin m_pend = 1'b1; m_pend_pc = tgt; end
    end else if (m_pend) begin
      e.redirect = 1'b1; e.redirect_pc = m_pend_pc; e.chk_pc = 1'b1; e.flush = 2'b11;
      m_pend = 1'b0;
    end else if (mis) begin
      e.redirect = 1'b1; e.redirect_pc = tgt; e.chk_pc = 1'b1; e.flush = 2'b11;
    end else if (st) begin
      e.pc_write = 1'b0; e.en = 4'b0111; e.flush = 2'b01;
    end else if (jp) begin
      e.redirect = 1'b1; e.redirect_pc = npc; e.chk_pc = 1'b1; e.flush = 2'b10;
    end
    exp_q.push_back(e);

    if (r) begin
      m_cyc = 0; m_stl = 0; m_fls = 0; m_known = 1'b1;
    end else begin
      m_cyc = m_cyc + 1;
      if (!e.pc_write) m_stl = m_stl + 1;
      if (e.flush[1])  m_fls = m_fls + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 0);
  endtask

  // Monitor: the combinational outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_write",    {31'd0, bus.pc_write},    {31'd0, e.pc_write});
      chk("redirect",    {31'd0, bus.redirect},    {31'd0, e.redirect});
      if (e.chk_pc) chk("redirect_pc", bus.redirect_pc, e.redirect_pc);
      chk("enables", {28'd0, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, {28'd0, e.en});
      chk("flushes", {30'd0, bus.if_id_flush, bus.id_ex_flush}, {30'd0, e.flush});
      chk("w4_pc_write", {31'd0, bus4.pc_write}, {31'd0, e.pc_write});
      if (e.known) begin
        chk("cycle_cnt",   bus.cycle_cnt, e.cyc);
        chk("stall_cnt",   bus.stall_cnt, e.stl);
        chk("flush_cnt",   bus.flush_cnt, e.fls);
        chk("w4_cycle_cnt", {28'd0, bus4.cycle_cnt}, {28'd0, e.cyc[3:0]});
        chk("w4_stall_cnt", {28'd0, bus4.stall_cnt}, {28'd0, e.stl[3:0]});
        chk("w4_flush_cnt", {28'd0, bus4.flush_cnt}, {28'd0, e.fls[3:0]});
      end
    end
  end

  initial begin
    // Reset, then straight-line run long enough to see the 4-bit counters wrap.
    step(1, 0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 0);
    step(1, 0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 0);
    idle(20);

    // Load-use stall for two cycles.
    step(0, 1, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 0);
    step(0, 1, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 0);
    idle(1);

    // Not-taken mispredict overrides a simultaneous jump.
    step(0, 0, 1, 32'h0040_0100, 1, 0, 1, 32'h0000_0800, 32'h0000_0040, 0);
    idle(1);

    // Taken mispredict while memory busy for 3 cycles; live ex inputs ignored on release.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'd0, 1, 1, 0, 32'h0000_1000, 32'h0000_0080, 1);
    step(0, 1, 1, 32'h0000_2222, 1, 0, 1, 32'h0000_3000, 32'h0000_0200, 0);
    idle(1);

    // Jump deferred behind a stall.
    step(0, 1, 1, 32'h0040_0020, 0, 0, 0, 32'd0, 32'd0, 0);
    step(0, 0, 1, 32'h0040_0020, 0, 0, 0, 32'd0, 32'd0, 0);
    idle(1);

    // Reset while holding a redirect discards it.
    step(0, 0, 0, 32'd0, 1, 1, 0, 32'h0000_5000, 32'h0000_0100, 1);
    step(0, 0, 0, 32'd0, 1, 1, 0, 32'h0000_5000, 32'h0000_0100, 1);
    step(1, 0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           (i % 7 == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom_range(0, 5) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
